// File: rtl/smem_console_writer.sv
// smem_console_writer: writer side of the text-mode screen memory.
// Turns a valid/ready stream of console commands (PUT, NEWLINE, CLEAR, HOME)
// into single-cycle write strobes into an nrows x ncols screen memory, while
// tracking a row/column cursor and its linear address.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   in_valid/in_ready      command handshake (in_ready is combinational)
//   in_cmd, in_char        command (0 PUT, 1 NEWLINE, 2 CLEAR, 3 HOME), char code
//   smem_wr/addr/wdata     registered write port towards the smem
//   cursor_addr            linear cursor position row*ncols+col
//   busy                   high while a full-screen clear is running
module smem_console_writer #(
    parameter int unsigned Nchars     = 4,
    parameter int unsigned ncols      = 40,
    parameter int unsigned nrows      = 30,
    parameter int unsigned smem_size  = 1200,
    parameter int unsigned blank_code = 0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   in_cmd,
    input  logic [$clog2(Nchars)-1:0]    in_char,
    output logic                         smem_wr,
    output logic [$clog2(smem_size)-1:0] smem_addr,
    output logic [$clog2(Nchars)-1:0]    smem_wdata,
    output logic [$clog2(smem_size)-1:0] cursor_addr,
    output logic                         busy
);

    localparam int unsigned CW   = $clog2(Nchars);
    localparam int unsigned AW   = $clog2(smem_size);
    localparam int unsigned COLW = $clog2(ncols);
    localparam int unsigned ROWW = $clog2(nrows);

    localparam logic [1:0] CMD_PUT     = 2'd0;
    localparam logic [1:0] CMD_NEWLINE = 2'd1;
    localparam logic [1:0] CMD_CLEAR   = 2'd2;
    localparam logic [1:0] CMD_HOME    = 2'd3;

    localparam logic [CW-1:0] BLANK = CW'(blank_code);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [COLW-1:0]   col_q, col_d;
    logic [ROWW-1:0]   row_q, row_d;
    logic [AW-1:0]     cur_q, cur_d;
    logic [AW-1:0]     clr_q, clr_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CW-1:0]     wdata_q, wdata_d;

    logic accept;
    logic last_col;
    logic last_row;
    logic clr_last;

    assign in_ready = resetn && (state_q == S_IDLE);
    assign accept   = in_valid && in_ready;
    assign last_col = (col_q == COLW'(ncols - 1));
    assign last_row = (row_q == ROWW'(nrows - 1));
    // clr_q holds the address written in the current cycle
    assign clr_last = (clr_q == AW'(smem_size - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept && (in_cmd == CMD_CLEAR)) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (clr_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Cursor, clear counter and write-port next values
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        cur_d   = cur_q;
        clr_d   = clr_q;
        wr_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (in_cmd)
                        CMD_PUT: begin
                            wr_d    = 1'b1;
                            addr_d  = cur_q;
                            wdata_d = in_char;
                            if (!last_col) begin
                                col_d = col_q + COLW'(1);
                                cur_d = cur_q + AW'(1);
                            end else if (!last_row) begin
                                col_d = '0;
                                row_d = row_q + ROWW'(1);
                                cur_d = cur_q + AW'(1);
                            end else begin
                                col_d = '0;
                                row_d = '0;
                                cur_d = '0;
                            end
                        end
                        CMD_NEWLINE: begin
                            col_d = '0;
                            if (!last_row) begin
                                row_d = row_q + ROWW'(1);
                                // start of next row without a multiplier
                                cur_d = cur_q - AW'(col_q) + AW'(ncols);
                            end else begin
                                row_d = '0;
                                cur_d = '0;
                            end
                        end
                        CMD_CLEAR: begin
                            // first blank write is issued on the accepting edge
                            wr_d    = 1'b1;
                            addr_d  = '0;
                            wdata_d = BLANK;
                            clr_d   = '0;
                        end
                        CMD_HOME: begin
                            col_d = '0;
                            row_d = '0;
                            cur_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            S_CLEAR: begin
                if (clr_last) begin
                    col_d = '0;
                    row_d = '0;
                    cur_d = '0;
                end else begin
                    wr_d    = 1'b1;
                    addr_d  = clr_q + AW'(1);
                    wdata_d = BLANK;
                    clr_d   = clr_q + AW'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            col_q   <= '0;
            row_q   <= '0;
            cur_q   <= '0;
            clr_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            cur_q   <= cur_d;
            clr_q   <= clr_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign smem_wr     = wr_q;
    assign smem_addr   = addr_q;
    assign smem_wdata  = wdata_q;
    assign cursor_addr = cur_q;
    assign busy        = (state_q == S_CLEAR);

endmodule

// File: doc/smem_console_writer.md
# smem_console_writer

Writer side of the text-mode screen memory (smem). Accepts a stream of character codes and console commands over a valid/ready handshake and turns them into single-cycle write strobes into the 30-row × 40-column smem that the VGA display path scans out. It maintains a row/column cursor and supports put-char with auto-advance and wrap, newline, home, and a multi-cycle full-screen clear. It sits between the processor's memory-mapped console port and the write port of the dual-port smem.

## Interface
- `Nchars`, default 4: number of character codes; code width is `$clog2(Nchars)`.
- `ncols`, default 40: characters per row.
- `nrows`, default 30: rows per screen.
- `smem_size`, default 1200: must equal `ncols*nrows`.
- `blank_code`, default 0: code written by CLEAR.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `in_valid` input 1: a command is offered.
- `in_ready` output 1: the block can accept a command this cycle.
- `in_cmd` input 2: 0 PUT, 1 NEWLINE, 2 CLEAR, 3 HOME.
- `in_char` input `$clog2(Nchars)`: character code; used by PUT only.
- `smem_wr` output 1: write strobe, one cycle per word.
- `smem_addr` output `$clog2(smem_size)`: write address.
- `smem_wdata` output `$clog2(Nchars)`: write data.
- `cursor_addr` output `$clog2(smem_size)`: linear cursor position, `row*ncols+col`.
- `busy` output 1: high while a CLEAR is in progress.

## Operation
- A command is accepted on a rising edge where `in_valid && in_ready`. `in_ready = resetn && (state==IDLE)` is combinational and does not depend on `in_valid`.
- The block has two states, IDLE and CLEAR. It holds `col`, `row` and a linear `cursor_addr` register, all kept consistent. No multiplier is used; the linear address is updated incrementally.
- PUT:
  - Writes `in_char` at the current `cursor_addr`.
  - Then advances the cursor. If `col==ncols-1`, `col` becomes 0 and `row` increments. If `row==nrows-1` as well, the cursor wraps to 0. There is no scrolling.
- NEWLINE:
  - No write.
  - `col` becomes 0 and `row` increments. On the last row the cursor wraps to row 0.
  - `cursor_addr` becomes `(row+1)*ncols`, or 0 on wrap. Compute it as `cursor_addr - col + ncols`.
- HOME: no write; cursor becomes 0.
- CLEAR:
  - Enters the CLEAR state. An internal counter steps from 0 to `smem_size-1`, writing `blank_code` to one address per cycle.
  - After the last write the block returns to IDLE with the cursor at 0.
  - `busy` is 1 exactly while in CLEAR.
- `smem_wr`, `smem_addr` and `smem_wdata` are registered.
  - `smem_wr` is 0 in every cycle that does not carry a write.
  - `smem_addr` and `smem_wdata` hold their last values when `smem_wr` is 0.
- Reset (`resetn` low at an edge), including during a CLEAR:
  - state = IDLE; cursor (`col`, `row`, `cursor_addr`) = 0.
  - `smem_wr` = 0; `smem_addr` = 0; `smem_wdata` = 0; `busy` = 0.
  - A clear in progress is aborted and its remaining addresses are left unwritten.
- `in_ready` is 0 while `resetn` is low. The block accepts commands from the first cycle `resetn` is high.

## Timing
- PUT accepted at edge N:
  - `smem_wr`=1 with the old cursor address and `in_char` in the cycle after N.
  - `cursor_addr` shows the advanced value after edge N.
  - Back-to-back PUTs sustain 1 write per cycle.
- NEWLINE and HOME accepted at edge N: cursor updated after edge N; no write.
- CLEAR accepted at edge N:
  - `busy`=1 and `in_ready`=0 from N+1.
  - Writes to addresses 0..`smem_size-1` are visible in cycles N+1..N+`smem_size`.
  - IDLE with `in_ready`=1, `busy`=0 and `cursor_addr`=0 from N+`smem_size`+1.
- `in_valid` asserted while `in_ready`=0 is ignored; the sender must hold it.
- All latencies are fixed; there is no other back-pressure.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles, then release. Required: `smem_wr`=0, `smem_addr`=0, `cursor_addr`=0, `busy`=0, `in_ready`=0 during reset and 1 on release.
- PUT stream: 3 back-to-back PUTs of codes 1, 2, 3 from cursor 0. Required: writes (0,1), (1,2), (2,3) on consecutive cycles; `cursor_addr`=3.
- Row and screen wrap:
  - HOME, then 39 PUTs, then PUT of code 2 puts the cursor at 40, i.e. row 1 col 0.
  - 1200 PUTs from HOME return the cursor to 0, and the last write goes to 1199.
- NEWLINE:
  - With the cursor at row 5 col 7 (addr 207), NEWLINE gives `cursor_addr`=240 and no write.
  - At row 29 col 3, NEWLINE gives `cursor_addr`=0.
- CLEAR:
  - Place the cursor at 500, then accept CLEAR. Required: 1200 consecutive writes of `blank_code` to 0..1199, `in_ready`=0 for exactly 1200 cycles, then cursor 0.
  - A PUT held valid during the clear is accepted only after it completes.
- Reset mid-CLEAR: assert `resetn`=0 after 100 clear writes. Required: `smem_wr`=0 from the next cycle, state IDLE, cursor 0, and no further writes.
